// File: rtl/stage_1.sv
// Prefetch FIFO: single-clock ring buffer of DEPTH entries with a whole-buffer flush.
// Latency: a pushed entry is visible at the head after the write edge; the head is a plain array read.
// Backpressure: the caller gates push on count < DEPTH; pop must only be asserted while count != 0.
module stage_1_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Instruction fetch: PC, imem req/ack with one request outstanding, prefetch FIFO to decode.
// Latency: request visible the edge after it is issued; instruction at the head the edge after its ack.
// Backpressure: i_stall only holds the head; fetch stops when the FIFO would be full and resumes on a pop.
module stage_1 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);
    localparam int          CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   addr_q;
    logic [31:0]   addr_d;
    logic [31:0]   b_target;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          ack;
    logic          push;
    logic          pop;
    logic          room;
    entry_t        push_dat;
    entry_t        head_dat;

    assign b_target = i_b_pc & ~32'h0000_0003;

    // An ack only means something while a request is on the bus.
    assign ack   = i_imem_ack && (state_q != IDLE);
    assign valid = (count != '0);
    assign pop   = valid && !i_stall && !i_b_taken;
    assign push  = ack && (state_q == WAIT) && !i_b_taken;

    assign push_dat   = '{pc: addr_q, inst: i_imem_data};
    assign count_next = count + CW'(push) - CW'(pop);
    assign room       = (count_next < FULL_LVL);

    stage_1_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (i_b_taken),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        if (i_b_taken) begin
            // A request still on the bus cannot be withdrawn; park the target until its ack.
            if (state_q == IDLE || ack) begin
                addr_d     = b_target;
                fetch_pc_d = b_target + 32'd4;
                state_d    = WAIT;
            end else begin
                fetch_pc_d = b_target;
                state_d    = DROP;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (room) begin
                        addr_d     = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        if (room) begin
                            addr_d     = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (ack) begin
                        addr_d     = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign inst      = valid ? head_dat.inst : NOP;
    assign pc        = valid ? head_dat.pc : 32'h0000_0000;
endmodule

// File: tb/tb_stage_1.sv
// Bench for stage_1: cycle table, directed redirect sequences, then random traffic against a stream scoreboard.
module tb_stage_1;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        b_taken = 1'b0;
    logic [31:0] b_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;

    stage_1 #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stall     (stall),
        .i_b_taken   (b_taken),
        .i_b_pc      (b_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .i_imem_ack  (imem_ack),
        .i_imem_data (imem_data),
        .valid       (valid),
        .inst        (inst),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        ack;
        logic        bt;
        logic [31:0] bpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input int r, input int s, input int a, input int bt,
                                input logic [31:0] bpc, input int e_req,
                                input logic [31:0] e_addr, input int e_vld,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rst = (r != 0);   v.stall = (s != 0);   v.ack = (a != 0);   v.bt = (bt != 0);
        v.bpc = bpc;        v.e_req = (e_req != 0); v.e_addr = e_addr;
        v.e_vld = (e_vld != 0); v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Memory returns addr^KEY, so every delivered instruction is checkable from its pc alone.
    task automatic drive(input logic r, input logic s, input logic a, input logic bt,
                         input logic [31:0] bpc);
        @(negedge clk);
        rst = r; stall = s; imem_ack = a; b_taken = bt; b_pc = bpc;
        imem_data = imem_addr ^ KEY;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_pc);
        chkb({tag, "_req"}, imem_req, e_req);
        chk({tag, "_addr"}, imem_addr, e_addr);
        chkb({tag, "_vld"}, valid, e_vld);
        chk({tag, "_pc"}, pc, e_vld ? e_pc : 32'h0);
        chk({tag, "_inst"}, inst, e_vld ? (e_pc ^ KEY) : NOP);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] d;
    logic        s;
    logic        a;
    logic        bt;
    logic        prev_bt;
    int          lat;
    int          wcnt;
    int          starve;
    int          max_starve;
    int          pops;

    initial begin
        //             rst st ack bt bpc          req addr          vld pc
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,        0, 32'h0000_0100, 0, 32'h0);
        tbl[1]  = mk(1, 0, 1, 0, 32'h0,        0, 32'h0000_0100, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0);
        tbl[3]  = mk(0, 0, 1, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h0000_0100);
        tbl[4]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0000_0104, 1, 32'h0000_0100);
        tbl[5]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0000_0104, 1, 32'h0000_0100);
        tbl[6]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0000_0104, 1, 32'h0000_0100);
        tbl[7]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0000_0104, 1, 32'h0000_0100);
        tbl[8]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0000_0104, 1, 32'h0000_0100);
        tbl[9]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0000_0104, 1, 32'h0000_0100);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,        1, 32'h0000_0108, 1, 32'h0000_0104);
        tbl[11] = mk(0, 0, 1, 0, 32'h0,        1, 32'h0000_010C, 1, 32'h0000_0108);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,        1, 32'h0000_010C, 0, 32'h0);
        tbl[13] = mk(0, 1, 1, 0, 32'h0,        1, 32'h0000_0110, 1, 32'h0000_010C);
        tbl[14] = mk(0, 1, 1, 1, 32'h0000_0303, 1, 32'h0000_0300, 0, 32'h0);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,        1, 32'h0000_0300, 0, 32'h0);
        tbl[16] = mk(0, 0, 1, 0, 32'h0,        1, 32'h0000_0304, 1, 32'h0000_0300);
        tbl[17] = mk(1, 0, 1, 0, 32'h0,        0, 32'h0000_0100, 0, 32'h0);
        tbl[18] = mk(0, 0, 1, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0);
        tbl[19] = mk(0, 0, 1, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h0000_0100);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].ack, tbl[i].bt, tbl[i].bpc);
            chk_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc);
        end

        // Redirect while a slow request is pending: old address held, its data dropped.
        drive(0, 0, 0, 0, 32'h0);           chk_out("slow_hold0", 1, 32'h0000_0104, 0, 32'h0);
        drive(0, 0, 0, 1, 32'h0000_0203);   chk_out("slow_redir", 1, 32'h0000_0104, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);           chk_out("slow_hold1", 1, 32'h0000_0104, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);           chk_out("slow_drop",  1, 32'h0000_0200, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);           chk_out("slow_tgt",   1, 32'h0000_0204, 1, 32'h0000_0200);

        // Two redirects while dropping: only the later target is fetched.
        drive(0, 1, 0, 1, 32'h0000_0300);   chk_out("dbl_r1",   1, 32'h0000_0204, 0, 32'h0);
        drive(0, 0, 0, 1, 32'h0000_0400);   chk_out("dbl_r2",   1, 32'h0000_0204, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);           chk_out("dbl_drop", 1, 32'h0000_0400, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);           chk_out("dbl_tgt",  1, 32'h0000_0404, 1, 32'h0000_0400);

        // Redirect from IDLE with a full FIFO, then a target that wraps past the top of memory.
        drive(0, 1, 1, 0, 32'h0);           chk_out("idle_full", 0, 32'h0000_0404, 1, 32'h0000_0400);
        drive(0, 1, 0, 1, 32'h0000_0500);   chk_out("idle_redir", 1, 32'h0000_0500, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);           chk_out("idle_tgt", 1, 32'h0000_0504, 1, 32'h0000_0500);
        drive(0, 0, 1, 1, 32'hFFFF_FFFE);   chk_out("wrap_redir", 1, 32'hFFFF_FFFC, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);           chk_out("wrap_top", 1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
        drive(0, 0, 1, 0, 32'h0);           chk_out("wrap_zero", 1, 32'h0000_0004, 1, 32'h0000_0000);

        // Random traffic: the delivered stream must be consecutive words from the last redirect.
        drive(1, 0, 0, 0, 32'h0);
        exp_pc = RST_PC;  lat = $urandom_range(0, 3);  wcnt = 0;
        starve = 0;  max_starve = 0;  pops = 0;  prev_bt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!valid) begin
                chk("rnd_nop", inst, NOP);
                chk("rnd_pc0", pc, 32'h0);
            end
            if (prev_bt) chkb("rnd_flush", valid, 1'b0);
            chk("rnd_align", {30'h0, imem_addr[1:0]}, 32'h0);

            s   = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 19) == 0);
            tgt = $urandom;
            if (imem_req) begin
                if (wcnt >= lat) begin
                    a = 1'b1;  wcnt = 0;  lat = $urandom_range(0, 3);
                end else begin
                    a = 1'b0;  wcnt++;
                end
                d = imem_addr ^ KEY;
            end else begin
                a = ($urandom_range(0, 1) == 1);
                d = $urandom;
            end

            if (valid && !s && !bt) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_inst", inst, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (bt) exp_pc = tgt & ~32'h0000_0003;

            if (bt || valid) starve = 0;
            else starve++;
            if (starve > max_starve) max_starve = starve;

            prev_bt = bt;
            rst = 1'b0;  stall = s;  imem_ack = a;  b_taken = bt;  b_pc = tgt;  imem_data = d;
        end
        @(posedge clk);
        #1;
        chkb("rnd_liveness", (max_starve <= 12), 1'b1);
        chkb("rnd_progress", (pops > 300), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
